// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and helper functions for the VGA raster generator.
package vga_pkg;

   localparam int unsigned DefHActive = 640;
   localparam int unsigned DefHFp     = 16;
   localparam int unsigned DefHSync   = 96;
   localparam int unsigned DefHBp     = 48;
   localparam int unsigned DefVActive = 480;
   localparam int unsigned DefVFp     = 10;
   localparam int unsigned DefVSync   = 2;
   localparam int unsigned DefVBp     = 33;
   localparam int unsigned DefHTotal  = DefHActive + DefHFp + DefHSync + DefHBp;
   localparam int unsigned DefVTotal  = DefVActive + DefVFp + DefVSync + DefVBp;

   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } ctrl_t;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return r;
   endfunction

   // Right-aligned top 'bits' bits of an 8-bit colour channel.
   function automatic logic [7:0] chan_msbs(input logic [7:0] chan, input int unsigned bits);
      return chan >> (8 - bits);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Request bus between the raster generator (master) and the framebuffer reader (slave).
interface vga_timing_gen_if #(
   parameter int unsigned CW = vga_pkg::clog2(vga_pkg::DefHTotal),
   parameter int unsigned LW = vga_pkg::clog2(vga_pkg::DefVTotal)
);
   logic          req_valid;
   logic [CW-1:0] req_col;
   logic [LW-1:0] req_line;
   logic          frame_start;
   logic          line_start;
   logic [23:0]   pixel;

   modport master (
      output req_valid, req_col, req_line, frame_start, line_start,
      input  pixel
   );

   modport slave (
      input  req_valid, req_col, req_line, frame_start, line_start,
      output pixel
   );
endinterface

// File: rtl/vga_delay_line.sv
// Width x Depth shift register with synchronous active-low clear; Depth 0 is a wire.
module vga_delay_line #(
   parameter int unsigned Width = 1,
   parameter int unsigned Depth = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   if (Depth == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_ni;
      assign q_o = d_i;
   end else begin : g_shift
      logic [Width-1:0] stage_q [Depth];
      logic [Width-1:0] stage_d [Depth];

      always_comb begin
         stage_d[0] = d_i;
         for (int unsigned i = 1; i < Depth; i++) stage_d[i] = stage_q[i-1];
      end

      always_ff @(posedge clk_i) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            if (!rst_ni) stage_q[i] <= '0;
            else         stage_q[i] <= stage_d[i];
         end
      end

      assign q_o = stage_q[Depth-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: registered requests ahead of a FETCH_LAT pipeline, then
// aligned HS/VS/DE/RGB. Define VGA_TEST_PATTERN_EN to add pattern_sel and an 8-bar test pattern.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = DefHActive,
   parameter int unsigned H_FP       = DefHFp,
   parameter int unsigned H_SYNC     = DefHSync,
   parameter int unsigned H_BP       = DefHBp,
   parameter int unsigned V_ACTIVE   = DefVActive,
   parameter int unsigned V_FP       = DefVFp,
   parameter int unsigned V_SYNC     = DefVSync,
   parameter int unsigned V_BP       = DefVBp,
   parameter bit          HS_POL     = 1'b0,
   parameter bit          VS_POL     = 1'b0,
   parameter int unsigned COLOR_BITS = 4,
   parameter int unsigned FETCH_LAT  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef VGA_TEST_PATTERN_EN
   input  logic                  pattern_sel,
`endif
   vga_timing_gen_if.master      bus,
   output logic [COLOR_BITS-1:0] R,
   output logic [COLOR_BITS-1:0] G,
   output logic [COLOR_BITS-1:0] B,
   output logic                  HS,
   output logic                  VS,
   output logic                  DE
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned CW      = clog2(H_TOTAL);
   localparam int unsigned LW      = clog2(V_TOTAL);
   localparam int unsigned HsFirst = H_ACTIVE + H_FP;
   localparam int unsigned HsLast  = HsFirst + H_SYNC - 1;
   localparam int unsigned VsFirst = V_ACTIVE + V_FP;
   localparam int unsigned VsLast  = VsFirst + V_SYNC - 1;

   logic [CW-1:0] h_q, h_d;
   logic [LW-1:0] v_q, v_d;
   logic run_q, run_d;
   logic req_valid_q, req_valid_d, frame_start_q, frame_start_d, line_start_q, line_start_d;
   logic hs_act_q, hs_act_d, vs_act_q, vs_act_d;

   // Counters hold at (0,0) for the first running cycle so exit from reset presents origin.
   always_comb begin
      h_d   = '0;
      v_d   = '0;
      run_d = 1'b1;
      if (run_q) begin
         if (h_q == CW'(H_TOTAL - 1)) begin
            v_d = (v_q == LW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
            v_d = v_q;
         end
      end
      req_valid_d   = (h_d < CW'(H_ACTIVE)) && (v_d < LW'(V_ACTIVE));
      hs_act_d      = (h_d >= CW'(HsFirst)) && (h_d <= CW'(HsLast));
      vs_act_d      = (v_d >= LW'(VsFirst)) && (v_d <= LW'(VsLast));
      line_start_d  = (h_d == '0);
      frame_start_d = (h_d == '0) && (v_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_q           <= '0;
         v_q           <= '0;
         run_q         <= 1'b0;
         req_valid_q   <= 1'b0;
         hs_act_q      <= 1'b0;
         vs_act_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         run_q         <= run_d;
         req_valid_q   <= req_valid_d;
         hs_act_q      <= hs_act_d;
         vs_act_q      <= vs_act_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.req_valid   = req_valid_q;
   assign bus.req_col     = h_q;
   assign bus.req_line    = v_q;
   assign bus.frame_start = frame_start_q;
   assign bus.line_start  = line_start_q;

   ctrl_t ctrl_in, ctrl_dly;
   assign ctrl_in = {req_valid_q, hs_act_q, vs_act_q};

   vga_delay_line #(
      .Width ($bits(ctrl_t)),
      .Depth (FETCH_LAT)
   ) u_ctrl_dly (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (ctrl_in),
      .q_o    (ctrl_dly)
   );

   logic [23:0] pix_eff;

`ifdef VGA_TEST_PATTERN_EN
   logic [2:0] bar, bar_dly;

   // Bar index = req_col*8/H_ACTIVE via ceil(k*H_ACTIVE/8) thresholds.
   always_comb begin
      bar = '0;
      for (int unsigned k = 1; k < 8; k++) begin
         if (h_q >= CW'((k * H_ACTIVE + 7) / 8)) bar = 3'(k);
      end
   end

   vga_delay_line #(
      .Width (3),
      .Depth (FETCH_LAT)
   ) u_bar_dly (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (bar),
      .q_o    (bar_dly)
   );

   assign pix_eff = pattern_sel ? {{8{bar_dly[2]}}, {8{bar_dly[1]}}, {8{bar_dly[0]}}} : bus.pixel;
`else
   assign pix_eff = bus.pixel;
`endif

   logic [COLOR_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic hs_q, hs_d, vs_q, vs_d, de_q, de_d;

   always_comb begin
      de_d = ctrl_dly.active;
      hs_d = ctrl_dly.hs ? HS_POL : ~HS_POL;
      vs_d = ctrl_dly.vs ? VS_POL : ~VS_POL;
      r_d  = '0;
      g_d  = '0;
      b_d  = '0;
      if (de_d) begin
         r_d = COLOR_BITS'(chan_msbs(pix_eff[23:16], COLOR_BITS));
         g_d = COLOR_BITS'(chan_msbs(pix_eff[15:8], COLOR_BITS));
         b_d = COLOR_BITS'(chan_msbs(pix_eff[7:0], COLOR_BITS));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q  <= '0;
         g_q  <= '0;
         b_q  <= '0;
         de_q <= 1'b0;
         hs_q <= ~HS_POL;
         vs_q <= ~VS_POL;
      end else begin
         r_q  <= r_d;
         g_q  <= g_d;
         b_q  <= b_d;
         de_q <= de_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
      end
   end

   assign R  = r_q;
   assign G  = g_q;
   assign B  = b_q;
   assign DE = de_q;
   assign HS = hs_q;
   assign VS = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster; positions derive from cycle arithmetic.
module tb_vga_timing_gen;

   localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
   localparam int VA = 40, VFP = 2, VSW = 2, VBP = 4;
   localparam int HT = HA + HFP + HSW + HBP;
   localparam int VT = VA + VFP + VSW + VBP;
   localparam int FT = HT * VT;
   localparam bit HPOL = 1'b0;
   localparam bit VPOL = 1'b1;
   localparam int CB = 4;
   localparam int FL = 3;
   localparam int CW = vga_pkg::clog2(HT);
   localparam int LW = vga_pkg::clog2(VT);

   typedef struct packed {
      logic          rv;
      logic [CW-1:0] col;
      logic [LW-1:0] line;
      logic          fs, ls, de, hs, vs;
      logic [CB-1:0] r, g, b;
   } exp_t;

   logic clk, rst_n;
   logic [CB-1:0] R, G, B;
   logic HS, VS, DE;
`ifdef VGA_TEST_PATTERN_EN
   logic pattern_sel;
`endif

   vga_timing_gen_if #(.CW(CW), .LW(LW)) bus ();

   vga_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
      .HS_POL (HPOL), .VS_POL (VPOL), .COLOR_BITS (CB), .FETCH_LAT (FL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef VGA_TEST_PATTERN_EN
      .pattern_sel (pattern_sel),
`endif
      .bus   (bus),
      .R     (R),
      .G     (G),
      .B     (B),
      .HS    (HS),
      .VS    (VS),
      .DE    (DE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t exp_q[$];
   logic [CW+LW-1:0] hist[$];
   int idx = -1;
   int checks = 0, errors = 0;
   bit started = 0;

   // Framebuffer content as a function of position.
   function automatic logic [23:0] fb(input logic [3:0] c4, input logic [3:0] l4);
      return {c4 ^ 4'h5, l4, l4 ^ c4, c4, ~l4, c4 ^ 4'hA};
   endfunction

   // Mode 0: constant A5C3F0, 1: random, 2: framebuffer, 3: test pattern.
   task automatic step(input bit rst_next, input int mode);
      exp_t e;
      logic [23:0] pix, f;
      logic [2:0] bar;
      int c, l, d, dc, dl;
      bit act;
      hist.push_back({bus.req_line, bus.req_col});
      if (hist.size() > FL + 1) void'(hist.pop_front());
      case (mode)
         0: pix = 24'hA5C3F0;
         2: pix = (hist.size() == FL + 1) ? fb(hist[0][3:0], hist[0][CW+3:CW]) : 24'h0;
         default: pix = 24'($urandom);
      endcase
      bus.pixel = pix;
`ifdef VGA_TEST_PATTERN_EN
      pattern_sel = (mode == 3);
`endif
      rst_n = rst_next;
      e = '0;
      e.hs = ~HPOL;
      e.vs = ~VPOL;
      if (!rst_next) begin
         idx = -1;
      end else begin
         idx = idx + 1;
         c = idx % HT;
         l = (idx / HT) % VT;
         e.rv = (c < HA) && (l < VA);
         e.col = CW'(c);
         e.line = LW'(l);
         e.fs = (c == 0) && (l == 0);
         e.ls = (c == 0);
         d = idx - 1 - FL;
         if (d >= 0) begin
            dc = d % HT;
            dl = (d / HT) % VT;
            act = (dc < HA) && (dl < VA);
            e.de = act;
            if (dc >= HA + HFP && dc < HA + HFP + HSW) e.hs = HPOL;
            if (dl >= VA + VFP && dl < VA + VFP + VSW) e.vs = VPOL;
            if (act) begin
               f = (mode == 2) ? fb(4'(dc), 4'(dl)) : pix;
               e.r = f[23 -: CB];
               e.g = f[15 -: CB];
               e.b = f[7 -: CB];
               if (mode == 3) begin
                  bar = 3'(dc * 8 / HA);
                  e.r = {CB{bar[2]}};
                  e.g = {CB{bar[1]}};
                  e.b = {CB{bar[0]}};
               end
            end
         end
      end
      exp_q.push_back(e);
      started = 1;
   endtask

   task automatic run(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         step(1'b1, mode);
      end
   endtask

   task automatic hold_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         step(1'b0, 1);
      end
   endtask

   // Monitor: pops one expectation per cycle and measures sync pulse widths/period.
   int t = 0, hs_start = -1, hs_len = 0, vs_len = 0;
   bit hs_prev = 0, vs_prev = 0, hs_valid = 0, vs_valid = 0, hs_on, vs_on;
   always @(posedge clk) begin
      exp_t e, a;
      #1;
      if (started) begin
         t++;
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty t=%0d", t);
         end else begin
            e = exp_q.pop_front();
            a.rv = bus.req_valid; a.col = bus.req_col; a.line = bus.req_line;
            a.fs = bus.frame_start; a.ls = bus.line_start;
            a.de = DE; a.hs = HS; a.vs = VS; a.r = R; a.g = G; a.b = B;
            checks++;
            if ({a.rv, a.col, a.line, a.fs, a.ls} !== {e.rv, e.col, e.line, e.fs, e.ls}) begin
               errors++;
               $display("FAIL req t=%0d got rv=%b col=%0d line=%0d fs=%b ls=%b want rv=%b col=%0d line=%0d fs=%b ls=%b",
                        t, a.rv, a.col, a.line, a.fs, a.ls, e.rv, e.col, e.line, e.fs, e.ls);
            end
            checks++;
            if ({a.de, a.hs, a.vs, a.r, a.g, a.b} !== {e.de, e.hs, e.vs, e.r, e.g, e.b}) begin
               errors++;
               $display("FAIL video t=%0d got de=%b hs=%b vs=%b rgb=%h/%h/%h want de=%b hs=%b vs=%b rgb=%h/%h/%h",
                        t, a.de, a.hs, a.vs, a.r, a.g, a.b, e.de, e.hs, e.vs, e.r, e.g, e.b);
            end
         end
         hs_on = (HS == HPOL);
         vs_on = (VS == VPOL);
         if (!rst_n) begin
            hs_start = -1; hs_valid = 0; vs_valid = 0;
         end else begin
            if (hs_on && !hs_prev) begin
               if (hs_start >= 0) begin
                  checks++;
                  if (t - hs_start != HT) begin
                     errors++;
                     $display("FAIL hs_period got %0d want %0d", t - hs_start, HT);
                  end
               end
               hs_start = t; hs_len = 0; hs_valid = 1;
            end
            if (hs_on) hs_len++;
            if (!hs_on && hs_prev && hs_valid) begin
               checks++;
               if (hs_len != HSW) begin
                  errors++;
                  $display("FAIL hs_width got %0d want %0d", hs_len, HSW);
               end
            end
            if (vs_on && !vs_prev) begin vs_len = 0; vs_valid = 1; end
            if (vs_on) vs_len++;
            if (!vs_on && vs_prev && vs_valid) begin
               checks++;
               if (vs_len != VSW * HT) begin
                  errors++;
                  $display("FAIL vs_width got %0d want %0d", vs_len, VSW * HT);
               end
            end
         end
         hs_prev = hs_on;
         vs_prev = vs_on;
      end
   end

   initial begin
      rst_n = 1'b0;
      bus.pixel = '0;
`ifdef VGA_TEST_PATTERN_EN
      pattern_sel = 1'b0;
`endif
      hold_reset(5);
      run(FT, 0);
      run(FT, 1);
      run(FT + 20 * HT + 30, 2);
      hold_reset(5);
      run(FT + FL + 10, 1);
      run(FT, 2);
`ifdef VGA_TEST_PATTERN_EN
      run(FT, 3);
`endif
      hold_reset(3);
      run(HT, 1);
      @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
